async_fifo_sync_read_control: RTL and testbench

Parametrised read-side controller for the asynchronous FIFO. It does the following in the read clock domain:
- synchronises the write-domain Gray pointer internally through a configurable synchroniser;
- maintains the read binary and Gray pointers;
- produces registered empty, almost-empty and fill-level outputs, plus an optional sticky underflow flag.

It sits between the read-port user logic, the dual-port FIFO memory (read address and enable) and the write-side controller (Gray pointer exchange).

---
 rtl/async_fifo_sync_read_control.sv | 93 +++++++++
 tb/tb_async_fifo_sync_read_control.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/async_fifo_sync_read_control.sv
// Read-side controller for the asynchronous FIFO: write-pointer synchroniser, read pointers, level/flags.
// Optional sticky underflow flag enabled by defining ASYNC_FIFO_RD_UNDERFLOW_EN.
module async_fifo_sync_read_control #(
   parameter int ADDR_BITS     = 3,
   parameter int SYNC_STAGES   = 2,
   parameter int AEMPTY_THRESH = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 fifo_pop,
   input  logic [ADDR_BITS:0]   write_gcode_ptr,
   output logic [ADDR_BITS-1:0] read_memory_addr,
   output logic                 read_mem_en,
   output logic [ADDR_BITS:0]   read_gcode_ptr,
   output logic                 fifo_empty,
   output logic                 fifo_almost_empty,
   output logic [ADDR_BITS:0]   fifo_level,
   output logic                 fifo_underflow
);

   localparam int PW = ADDR_BITS + 1;

   logic [PW-1:0] sync_reg [SYNC_STAGES];
   logic [PW-1:0] wgray_s_next;
   logic [PW-1:0] wbin_s_next;
   logic [PW-1:0] rd_bin_reg;
   logic [PW-1:0] rd_bin_next;
   logic [PW-1:0] lvl_next;
   logic          accept;

   // Plain flop chain, no logic between stages.
   generate
      for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
         if (gi == 0) begin : g_first
            always_ff @(posedge clk or posedge reset) begin
               if (reset) sync_reg[gi] <= '0;
               else       sync_reg[gi] <= write_gcode_ptr;
            end
         end else begin : g_next
            always_ff @(posedge clk or posedge reset) begin
               if (reset) sync_reg[gi] <= '0;
               else       sync_reg[gi] <= sync_reg[gi-1];
            end
         end
      end
   endgenerate

   // Flags are computed from the last stage's D input so they land on the same edge as that stage.
   assign wgray_s_next = sync_reg[SYNC_STAGES-2];

   generate
      for (genvar gi = 0; gi < PW; gi++) begin : g_g2b
         assign wbin_s_next[gi] = ^wgray_s_next[PW-1:gi];
      end
   endgenerate

   assign accept      = fifo_pop && !fifo_empty;
   assign read_mem_en = accept;
   assign rd_bin_next = rd_bin_reg + {{(PW-1){1'b0}}, accept};
   assign lvl_next    = wbin_s_next - rd_bin_next;

   assign read_memory_addr = rd_bin_reg[ADDR_BITS-1:0];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_bin_reg        <= '0;
         read_gcode_ptr    <= '0;
         fifo_level        <= '0;
         fifo_empty        <= 1'b1;
         fifo_almost_empty <= 1'b1;
      end else begin
         rd_bin_reg        <= rd_bin_next;
         read_gcode_ptr    <= rd_bin_next ^ (rd_bin_next >> 1);
         fifo_level        <= lvl_next;
         fifo_empty        <= (lvl_next == '0);
         fifo_almost_empty <= (lvl_next <= PW'(AEMPTY_THRESH));
      end
   end

`ifdef ASYNC_FIFO_RD_UNDERFLOW_EN
   logic underflow_reg;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)                        underflow_reg <= 1'b0;
      else if (fifo_pop && fifo_empty)  underflow_reg <= 1'b1;
   end

   assign fifo_underflow = underflow_reg;
`else
   assign fifo_underflow = 1'b0;
`endif

endmodule

// File: tb/tb_async_fifo_sync_read_control.sv
// Bench for async_fifo_sync_read_control: directed and random pops/writes against a count-based model.
module tb_async_fifo_sync_read_control;

   localparam int AB = 3;
   localparam int SS = 2;
   localparam int AT = 1;
   localparam int PW = AB + 1;
   localparam int DEPTH = 1 << AB;
   localparam int PMOD = 1 << PW;
`ifdef ASYNC_FIFO_RD_UNDERFLOW_EN
   localparam bit UF_EN = 1'b1;
`else
   localparam bit UF_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          fifo_pop = 1'b0;
   logic [PW-1:0] write_gcode_ptr = '0;
   logic [AB-1:0] read_memory_addr;
   logic          read_mem_en;
   logic [PW-1:0] read_gcode_ptr;
   logic          fifo_empty;
   logic          fifo_almost_empty;
   logic [PW-1:0] fifo_level;
   logic          fifo_underflow;

   async_fifo_sync_read_control #(
      .ADDR_BITS(AB), .SYNC_STAGES(SS), .AEMPTY_THRESH(AT)
   ) dut (
      .clk(clk), .reset(reset), .fifo_pop(fifo_pop),
      .write_gcode_ptr(write_gcode_ptr),
      .read_memory_addr(read_memory_addr), .read_mem_en(read_mem_en),
      .read_gcode_ptr(read_gcode_ptr), .fifo_empty(fifo_empty),
      .fifo_almost_empty(fifo_almost_empty), .fifo_level(fifo_level),
      .fifo_underflow(fifo_underflow)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fails  = 0;
   int rd_cnt, wr_cnt, lvl_m;
   bit uf_m;
   int cap_q[$];

   function automatic logic [PW-1:0] gray(input int v);
      logic [PW-1:0] b;
      b = PW'(v % PMOD);
      return b ^ (b >> 1);
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      rd_cnt = 0; wr_cnt = 0; lvl_m = 0; uf_m = 1'b0;
      cap_q = {};
      repeat (SS) cap_q.push_back(0);
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_level"},  32'(fifo_level), 0);
      check({tag, "_empty"},  32'(fifo_empty), 1);
      check({tag, "_aempty"}, 32'(fifo_almost_empty), 1);
      check({tag, "_addr"},   32'(read_memory_addr), 0);
      check({tag, "_gptr"},   32'(read_gcode_ptr), 0);
      check({tag, "_uf"},     32'(fifo_underflow), 0);
      check({tag, "_rden"},   32'(read_mem_en), 0);
   endtask

   // One clock cycle: drive inputs, check the combinational strobe, advance the model, check registers.
   task automatic step(input bit pop, input int wc);
      bit acc;
      @(negedge clk);
      fifo_pop = pop;
      wr_cnt = wc;
      write_gcode_ptr = gray(wc);
      acc = pop && (lvl_m != 0);
      #1 check("read_mem_en", 32'(read_mem_en), 32'(acc));
      @(posedge clk);
      if (acc) rd_cnt++;
      if (pop && lvl_m == 0 && UF_EN) uf_m = 1'b1;
      cap_q.push_back(wc);
      void'(cap_q.pop_front());
      lvl_m = (((cap_q[0] - rd_cnt) % PMOD) + PMOD) % PMOD;
      #1;
      check("fifo_level", 32'(fifo_level), 32'(lvl_m));
      check("fifo_empty", 32'(fifo_empty), 32'(lvl_m == 0));
      check("fifo_almost_empty", 32'(fifo_almost_empty), 32'(lvl_m <= AT));
      check("read_memory_addr", 32'(read_memory_addr), 32'(rd_cnt % DEPTH));
      check("read_gcode_ptr", 32'(read_gcode_ptr), 32'(gray(rd_cnt)));
      check("fifo_underflow", 32'(fifo_underflow), 32'(uf_m));
      $display("step pop=%0d wr=%0d rd=%0d level=%0d empty=%0d addr=%0d gptr=%b",
               pop, wc, rd_cnt, fifo_level, fifo_empty, read_memory_addr, read_gcode_ptr);
   endtask

   initial begin
      int wc, adv;
      bit pop;
      model_reset();
      repeat (2) @(posedge clk);
      #1 check_reset_vals("reset");
      @(negedge clk);
      reset = 1'b0;

      // Pops while empty
      repeat (3) step(1'b1, 0);
      // Five entries arrive, then drain them
      repeat (2) step(1'b0, 5);
      repeat (5) step(1'b1, 5);
      // Fill to full and drain across the wrap bit
      repeat (2) step(1'b0, 13);
      repeat (9) step(1'b1, 13);
      // Pointer wraps past 15
      repeat (2) step(1'b0, 18);
      repeat (5) step(1'b1, 18);
      // Level 3, then pop while the write pointer advances
      wc = rd_cnt + 3;
      repeat (2) step(1'b0, wc);
      step(1'b1, wc + 1);
      step(1'b1, wc + 1);
      repeat (3) step(1'b0, wc + 1);

      // Random pops and writes, never exceeding the FIFO depth
      for (int i = 0; i < 300; i++) begin
         pop = 1'($urandom % 2);
         adv = int'($urandom_range(0, 2));
         wc = wr_cnt + adv;
         if (wc > rd_cnt + DEPTH) wc = rd_cnt + DEPTH;
         step(pop, wc);
      end

      // Asynchronous reset mid-operation at level 4 with a pop in flight
      wc = rd_cnt + 4;
      repeat (3) step(1'b0, wc);
      @(negedge clk);
      fifo_pop = 1'b1;
      #1 check("pre_reset_rden", 32'(read_mem_en), 1);
      #1 reset = 1'b1;
      #1 check_reset_vals("midreset");
      write_gcode_ptr = '0;
      @(posedge clk);
      #1 check_reset_vals("held_reset");
      @(negedge clk);
      reset = 1'b0;
      fifo_pop = 1'b0;
      model_reset();
      repeat (2) step(1'b0, 3);
      repeat (4) step(1'b1, 3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
